// File: rtl/mem_stage_lsu_pkg.sv
// Shared pipeline types for the MEM-stage load/store unit and its helpers.
package mem_stage_lsu_pkg;

  typedef enum logic [1:0] {
    MEM_NONE  = 2'b00,
    MEM_STORE = 2'b01,
    MEM_LOAD  = 2'b10
  } mem_op_e;

  typedef enum logic [1:0] {
    DT_BYTE = 2'b00,
    DT_HALF = 2'b01,
    DT_WORD = 2'b10
  } data_type_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_WAIT = 2'b10,
    ST_DONE = 2'b11
  } lsu_state_e;

endpackage

// File: rtl/mem_stage_lsu_align.sv
// Byte-lane alignment: byte enables, store replication, load extraction/extension
// and misalignment detection. Purely combinational.
module lsu_align
  import mem_stage_lsu_pkg::*;
(
  input  logic [1:0]  i_data_type,
  input  logic [1:0]  i_byte_off,
  input  logic        i_unsigned,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rdata,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  output logic [31:0] o_rdata,
  output logic        o_misaligned
);

  logic [31:0] shifted;
  logic [15:0] lane16;

  always_comb begin
    shifted      = i_rdata >> {i_byte_off, 3'b000};
    lane16       = i_byte_off[1] ? i_rdata[31:16] : i_rdata[15:0];
    o_be         = 4'b1111;
    o_wdata      = i_wdata;
    o_rdata      = i_rdata;
    o_misaligned = (i_byte_off != 2'b00);
    case (i_data_type)
      DT_BYTE: begin
        o_be         = 4'b0001 << i_byte_off;
        o_wdata      = {4{i_wdata[7:0]}};
        o_rdata      = {{24{~i_unsigned & shifted[7]}}, shifted[7:0]};
        o_misaligned = 1'b0;
      end
      DT_HALF: begin
        o_be         = 4'b0011 << {i_byte_off[1], 1'b0};
        o_wdata      = {2{i_wdata[15:0]}};
        o_rdata      = {{16{~i_unsigned & lane16[15]}}, lane16};
        o_misaligned = i_byte_off[0];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: drives a req/gnt/rvalid data port, stalls the
// EX/MEM register while an access is outstanding and returns aligned load data.
module mem_stage_lsu
  import mem_stage_lsu_pkg::*;
#(
  parameter int TIMEOUT = 64
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [1:0]  i_mem_op,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  input  logic [1:0]  i_data_type,
  input  logic        i_unsigned,
  output logic        o_stall,
  output logic [31:0] o_rdata,
  output logic        o_rdata_valid,
  output logic        o_misaligned,
  output logic        o_timeout,
  output logic        o_dmem_req,
  output logic        o_dmem_we,
  output logic [31:0] o_dmem_addr,
  output logic [3:0]  o_dmem_be,
  output logic [31:0] o_dmem_wdata,
  input  logic        i_dmem_gnt,
  input  logic        i_dmem_rvalid,
  input  logic [31:0] i_dmem_rdata
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  lsu_state_e  state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [1:0]  dtype_q, dtype_d;
  logic        uns_q, uns_d;
  logic        we_q, we_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        timeout_q, timeout_d;
  logic        mis_q, mis_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic        idle, op_valid, tmo_hit;
  logic [1:0]  a_type, a_off;
  logic        a_uns, a_mis;
  logic [3:0]  a_be;
  logic [31:0] a_wdata, a_rdata;

  // In IDLE the aligner sees the incoming instruction; afterwards the latched one.
  assign idle     = (state_q == ST_IDLE);
  assign op_valid = (i_mem_op == MEM_STORE) || (i_mem_op == MEM_LOAD);
  assign a_type   = idle ? i_data_type : dtype_q;
  assign a_off    = idle ? i_addr[1:0] : addr_q[1:0];
  assign a_uns    = idle ? i_unsigned  : uns_q;
  assign tmo_hit  = (TIMEOUT != 0) && (cnt_q == CW'(TIMEOUT - 1));

  lsu_align u_align (
    .i_data_type  (a_type),
    .i_byte_off   (a_off),
    .i_unsigned   (a_uns),
    .i_wdata      (i_wdata),
    .i_rdata      (i_dmem_rdata),
    .o_be         (a_be),
    .o_wdata      (a_wdata),
    .o_rdata      (a_rdata),
    .o_misaligned (a_mis)
  );

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    dtype_d   = dtype_q;
    uns_d     = uns_q;
    we_d      = we_q;
    be_d      = be_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
    mis_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (op_valid) begin
          if (a_mis) begin
            mis_d = 1'b1;
          end else begin
            state_d = ST_REQ;
            addr_d  = i_addr;
            dtype_d = i_data_type;
            uns_d   = i_unsigned;
            we_d    = (i_mem_op == MEM_STORE);
            be_d    = a_be;
            wdata_d = (i_mem_op == MEM_STORE) ? a_wdata : '0;
            cnt_d   = '0;
          end
        end
      end
      ST_REQ: begin
        cnt_d = cnt_q + CW'(1);
        if (i_dmem_gnt) begin
          if (we_q) begin
            state_d = ST_DONE;
          end else if (i_dmem_rvalid) begin
            rdata_d = a_rdata;
            state_d = ST_DONE;
          end else begin
            state_d = ST_WAIT;
          end
        end else if (tmo_hit) begin
          timeout_d = 1'b1;
          rdata_d   = '0;
          state_d   = ST_DONE;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q + CW'(1);
        if (i_dmem_rvalid) begin
          rdata_d = a_rdata;
          state_d = ST_DONE;
        end else if (tmo_hit) begin
          timeout_d = 1'b1;
          rdata_d   = '0;
          state_d   = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      dtype_q   <= '0;
      uns_q     <= 1'b0;
      we_q      <= 1'b0;
      be_q      <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
      mis_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      dtype_q   <= dtype_d;
      uns_q     <= uns_d;
      we_q      <= we_d;
      be_q      <= be_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
      mis_q     <= mis_d;
    end
  end

  assign o_stall       = (idle && op_valid && !a_mis) || (state_q == ST_REQ) || (state_q == ST_WAIT);
  assign o_dmem_req    = (state_q == ST_REQ);
  assign o_dmem_we     = we_q;
  assign o_dmem_addr   = {addr_q[31:2], 2'b00};
  assign o_dmem_be     = be_q;
  assign o_dmem_wdata  = wdata_q;
  assign o_rdata       = rdata_q;
  assign o_rdata_valid = (state_q == ST_DONE) && !we_q;
  assign o_timeout     = timeout_q;
  assign o_misaligned  = mis_q;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Self-checking bench for mem_stage_lsu: directed scenarios plus randomized
// accesses checked against an arithmetic reference model.
module tb_mem_stage_lsu;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic [1:0]  i_mem_op = '0;
  logic [31:0] i_addr = '0;
  logic [31:0] i_wdata = '0;
  logic [1:0]  i_data_type = '0;
  logic        i_unsigned = 1'b0;
  logic        o_stall;
  logic [31:0] o_rdata;
  logic        o_rdata_valid;
  logic        o_misaligned;
  logic        o_timeout;
  logic        o_dmem_req;
  logic        o_dmem_we;
  logic [31:0] o_dmem_addr;
  logic [3:0]  o_dmem_be;
  logic [31:0] o_dmem_wdata;
  logic        i_dmem_gnt = 1'b0;
  logic        i_dmem_rvalid = 1'b0;
  logic [31:0] i_dmem_rdata = '0;

  int tests = 0;
  int fails = 0;

  // observations collected by run_access
  int          obs_stall, obs_req, obs_gnt, obs_rv, obs_to, obs_mis, obs_unstable;
  logic [3:0]  obs_be;
  logic [31:0] obs_addr, obs_wdata, obs_rvdata, obs_rdata_after;
  logic        obs_we;
  logic [31:0] model_rdata;

  mem_stage_lsu #(.TIMEOUT(8)) dut (
    .i_clk         (i_clk),
    .i_rst_n       (i_rst_n),
    .i_mem_op      (i_mem_op),
    .i_addr        (i_addr),
    .i_wdata       (i_wdata),
    .i_data_type   (i_data_type),
    .i_unsigned    (i_unsigned),
    .o_stall       (o_stall),
    .o_rdata       (o_rdata),
    .o_rdata_valid (o_rdata_valid),
    .o_misaligned  (o_misaligned),
    .o_timeout     (o_timeout),
    .o_dmem_req    (o_dmem_req),
    .o_dmem_we     (o_dmem_we),
    .o_dmem_addr   (o_dmem_addr),
    .o_dmem_be     (o_dmem_be),
    .o_dmem_wdata  (o_dmem_wdata),
    .i_dmem_gnt    (i_dmem_gnt),
    .i_dmem_rvalid (i_dmem_rvalid),
    .i_dmem_rdata  (i_dmem_rdata)
  );

  always #5 i_clk = ~i_clk;

  // ---------------- reference model ----------------
  function automatic int size_of(input logic [1:0] dt);
    return (dt == 2'd0) ? 1 : (dt == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic [3:0] exp_be(input logic [31:0] addr, input logic [1:0] dt);
    int sz = size_of(dt);
    int off = int'(addr % 4);
    logic [3:0] m = 4'((1 << sz) - 1);
    off = off - (off % sz);
    return m << off;
  endfunction

  function automatic logic [31:0] exp_wdata(input logic [31:0] wd, input logic [1:0] dt);
    int sz = size_of(dt);
    logic [31:0] r = '0;
    for (int i = 0; i < 4; i++)
      r = r | (((wd >> (8 * (i % sz))) & 32'hFF) << (8 * i));
    return r;
  endfunction

  function automatic logic [31:0] exp_load(input logic [31:0] addr, input logic [1:0] dt,
                                           input logic uns, input logic [31:0] rd);
    int sz = size_of(dt);
    int off = int'(addr % 4);
    longint mask = (longint'(1) << (8 * sz)) - 1;
    longint v = (longint'(rd) >> (8 * off)) & mask;
    if (!uns && sz < 4 && (((v >> (8 * sz - 1)) & 1) == 1)) v = v | ~mask;
    return v[31:0];
  endfunction

  // ---------------- driver ----------------
  task automatic run_access(input logic [1:0] op, input logic [31:0] addr, input logic [31:0] wd,
                            input logic [1:0] dt, input logic uns, input int gnt_wait,
                            input int rv_wait, input logic [31:0] rd, input bit never_gnt);
    int  req_n = 0;
    int  wcnt = 0;
    bit  rv_sent = 0;
    bit  done = 0;
    logic [31:0] first_addr = '0;
    logic [3:0]  first_be = '0;
    obs_stall = 0; obs_req = 0; obs_gnt = 0; obs_rv = 0; obs_to = 0; obs_mis = 0; obs_unstable = 0;
    obs_be = '0; obs_addr = '0; obs_wdata = '0; obs_we = 0; obs_rvdata = '0;
    @(posedge i_clk); #1;
    i_mem_op = op; i_addr = addr; i_wdata = wd; i_data_type = dt; i_unsigned = uns;
    for (int c = 0; c < 40; c++) begin
      if (c > 0) begin @(posedge i_clk); #1; end
      i_dmem_gnt = 0; i_dmem_rvalid = 0; i_dmem_rdata = $urandom;
      if (o_dmem_req) begin
        i_dmem_gnt = !never_gnt && (req_n == gnt_wait);
        if (i_dmem_gnt && op == 2'b10 && rv_wait == 0) begin
          i_dmem_rvalid = 1; i_dmem_rdata = rd; rv_sent = 1;
        end
        req_n++;
      end else if (obs_gnt > 0 && op == 2'b10 && !rv_sent) begin
        wcnt++;
        if (wcnt == rv_wait) begin i_dmem_rvalid = 1; i_dmem_rdata = rd; rv_sent = 1; end
      end
      @(negedge i_clk);
      if (o_stall) obs_stall++;
      if (o_misaligned) obs_mis++;
      if (o_timeout) obs_to++;
      if (o_rdata_valid) begin obs_rv++; obs_rvdata = o_rdata; end
      if (o_dmem_req) begin
        if (obs_req == 0) begin first_addr = o_dmem_addr; first_be = o_dmem_be; end
        else if (o_dmem_addr !== first_addr || o_dmem_be !== first_be) obs_unstable++;
        obs_req++;
        if (i_dmem_gnt) begin
          obs_gnt++; obs_be = o_dmem_be; obs_addr = o_dmem_addr; obs_wdata = o_dmem_wdata; obs_we = o_dmem_we;
        end
      end
      if (!o_stall) begin done = 1; break; end
    end
    if (!done) begin
      tests++; fails++;
      $display("FAIL access_budget: stall still %0b after 40 cycles, required 0", o_stall);
    end
    @(posedge i_clk); #1;
    i_mem_op = 2'b00; i_dmem_gnt = 0; i_dmem_rvalid = 0;
    @(negedge i_clk);
    if (o_misaligned) obs_mis++;
    if (o_timeout) obs_to++;
    if (o_rdata_valid) obs_rv++;
    obs_rdata_after = o_rdata;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    i_rst_n = 0;
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    tests++; if (o_stall !== 1'b0) begin fails++; $display("FAIL reset_stall: got %0b required 0", o_stall); end
    tests++; if (o_dmem_req !== 1'b0 || o_dmem_we !== 1'b0) begin fails++; $display("FAIL reset_req_we: got %0b%0b required 00", o_dmem_req, o_dmem_we); end
    tests++; if (o_rdata !== 32'h0 || o_rdata_valid !== 1'b0) begin fails++; $display("FAIL reset_rdata: got %h/%0b required 0/0", o_rdata, o_rdata_valid); end
    tests++; if (o_misaligned !== 1'b0 || o_timeout !== 1'b0) begin fails++; $display("FAIL reset_pulses: got %0b%0b required 00", o_misaligned, o_timeout); end
    tests++; if (o_dmem_addr !== 32'h0 || o_dmem_be !== 4'h0 || o_dmem_wdata !== 32'h0) begin fails++; $display("FAIL reset_port: got %h/%h/%h required 0", o_dmem_addr, o_dmem_be, o_dmem_wdata); end
    @(posedge i_clk); #1;
    i_rst_n = 1;
    model_rdata = '0;
  endtask

  task automatic test_word_store();
    run_access(2'b01, 32'h0000_1004, 32'hDEAD_BEEF, 2'b10, 0, 1, 0, '0, 0);
    tests++; if (obs_be !== 4'b1111) begin fails++; $display("FAIL wstore_be: got %b required 1111", obs_be); end
    tests++; if (obs_addr !== 32'h1004) begin fails++; $display("FAIL wstore_addr: got %h required 00001004", obs_addr); end
    tests++; if (obs_wdata !== 32'hDEADBEEF || obs_we !== 1'b1) begin fails++; $display("FAIL wstore_data: got %h we=%0b required deadbeef we=1", obs_wdata, obs_we); end
    tests++; if (obs_stall != 3) begin fails++; $display("FAIL wstore_stall: got %0d cycles required 3", obs_stall); end
    tests++; if (obs_gnt != 1 || obs_req != 2) begin fails++; $display("FAIL wstore_req: got gnt=%0d req=%0d required 1/2", obs_gnt, obs_req); end
    tests++; if (obs_rv != 0 || obs_rdata_after !== model_rdata) begin fails++; $display("FAIL wstore_rdata: got rv=%0d rdata=%h required 0/%h", obs_rv, obs_rdata_after, model_rdata); end
  endtask

  task automatic test_byte_load();
    run_access(2'b10, 32'h0000_2003, '0, 2'b00, 0, 0, 0, 32'h80FF_1234, 0);
    tests++; if (obs_be !== 4'b1000) begin fails++; $display("FAIL bload_be: got %b required 1000", obs_be); end
    tests++; if (obs_rv != 1 || obs_rvdata !== 32'hFFFF_FF80) begin fails++; $display("FAIL bload_signed: got rv=%0d data=%h required 1/ffffff80", obs_rv, obs_rvdata); end
    tests++; if (obs_stall != 2) begin fails++; $display("FAIL bload_stall: got %0d required 2", obs_stall); end
    run_access(2'b10, 32'h0000_2003, '0, 2'b00, 1, 0, 0, 32'h80FF_1234, 0);
    tests++; if (obs_rv != 1 || obs_rvdata !== 32'h0000_0080) begin fails++; $display("FAIL bload_unsigned: got rv=%0d data=%h required 1/00000080", obs_rv, obs_rvdata); end
    tests++; if (obs_rdata_after !== 32'h0000_0080) begin fails++; $display("FAIL bload_hold: got %h required 00000080", obs_rdata_after); end
  endtask

  task automatic test_half_load();
    run_access(2'b10, 32'h0000_2002, '0, 2'b01, 0, 0, 3, 32'h8001_0000, 0);
    tests++; if (obs_rv != 1 || obs_rvdata !== 32'hFFFF_8001) begin fails++; $display("FAIL hload_data: got rv=%0d data=%h required 1/ffff8001", obs_rv, obs_rvdata); end
    tests++; if (obs_stall != 5 || obs_req != 1) begin fails++; $display("FAIL hload_timing: got stall=%0d req=%0d required 5/1", obs_stall, obs_req); end
    tests++; if (obs_be !== 4'b1100) begin fails++; $display("FAIL hload_be: got %b required 1100", obs_be); end
    model_rdata = 32'hFFFF_8001;
  endtask

  task automatic test_misaligned();
    run_access(2'b01, 32'h0000_3001, 32'h1234_5678, 2'b10, 0, 0, 0, '0, 0);
    tests++; if (obs_mis != 1) begin fails++; $display("FAIL mis_pulse: got %0d pulses required 1", obs_mis); end
    tests++; if (obs_req != 0 || obs_stall != 0) begin fails++; $display("FAIL mis_noreq: got req=%0d stall=%0d required 0/0", obs_req, obs_stall); end
    tests++; if (obs_rdata_after !== model_rdata) begin fails++; $display("FAIL mis_rdata_hold: got %h required %h", obs_rdata_after, model_rdata); end
  endtask

  task automatic test_timeout();
    run_access(2'b10, 32'h0000_4000, '0, 2'b10, 0, 0, 0, 32'h5555_5555, 1);
    tests++; if (obs_to != 1) begin fails++; $display("FAIL tmo_pulse: got %0d pulses required 1", obs_to); end
    tests++; if (obs_req != 8 || obs_stall != 9) begin fails++; $display("FAIL tmo_cycles: got req=%0d stall=%0d required 8/9", obs_req, obs_stall); end
    tests++; if (obs_rdata_after !== 32'h0) begin fails++; $display("FAIL tmo_rdata: got %h required 00000000", obs_rdata_after); end
    model_rdata = '0;
    run_access(2'b01, 32'h0000_4008, 32'hA5A5_0011, 2'b00, 0, 0, 0, '0, 0);
    tests++; if (obs_gnt != 1 || obs_be !== 4'b0001) begin fails++; $display("FAIL tmo_recover: got gnt=%0d be=%b required 1/0001", obs_gnt, obs_be); end
  endtask

  task automatic test_random(input int n);
    for (int k = 0; k < n; k++) begin
      int          r = $urandom_range(0, 9);
      logic [1:0]  op = (r == 0) ? 2'b00 : (r == 1) ? 2'b11 : (r < 6) ? 2'b01 : 2'b10;
      logic [1:0]  dt = 2'($urandom_range(0, 3));
      logic [31:0] addr = $urandom;
      logic [31:0] wd = $urandom;
      logic [31:0] rd = $urandom;
      logic        uns = 1'($urandom_range(0, 1));
      int          gw = $urandom_range(0, 3);
      int          rw = $urandom_range(0, 3);
      int          sz = size_of(dt);
      bit          valid, mis, go, ld;
      int          exp_stall;
      if ($urandom_range(0, 9) < 7) addr = addr - (addr % sz);
      valid = (op == 2'b01) || (op == 2'b10);
      mis   = valid && ((addr % sz) != 0);
      go    = valid && !mis;
      ld    = go && (op == 2'b10);
      exp_stall = !go ? 0 : (ld ? 2 + gw + rw : 2 + gw);
      run_access(op, addr, wd, dt, uns, gw, rw, rd, 0);
      if (ld) model_rdata = exp_load(addr, dt, uns, rd);
      tests++; if (obs_stall != exp_stall || obs_gnt != int'(go) || obs_mis != int'(mis)) begin
        fails++; $display("FAIL rnd_flow[%0d]: got stall=%0d gnt=%0d mis=%0d required %0d/%0d/%0d", k, obs_stall, obs_gnt, obs_mis, exp_stall, go, mis);
      end
      if (go) begin
        tests++; if (obs_be !== exp_be(addr, dt) || obs_addr !== {addr[31:2], 2'b00} || obs_we !== (op == 2'b01) || obs_unstable != 0) begin
          fails++; $display("FAIL rnd_port[%0d]: got be=%b addr=%h we=%0b unstable=%0d required be=%b addr=%h", k, obs_be, obs_addr, obs_we, obs_unstable, exp_be(addr, dt), {addr[31:2], 2'b00});
        end
      end
      if (go && op == 2'b01) begin
        tests++; if (obs_wdata !== exp_wdata(wd, dt)) begin fails++; $display("FAIL rnd_wdata[%0d]: got %h required %h", k, obs_wdata, exp_wdata(wd, dt)); end
      end
      if (ld) begin
        tests++; if (obs_rv != 1 || obs_rvdata !== model_rdata) begin fails++; $display("FAIL rnd_load[%0d]: got rv=%0d data=%h required 1/%h", k, obs_rv, obs_rvdata, model_rdata); end
      end
      tests++; if (obs_rdata_after !== model_rdata || obs_to != 0 || (!ld && obs_rv != 0)) begin
        fails++; $display("FAIL rnd_after[%0d]: got rdata=%h to=%0d rv=%0d required %h/0", k, obs_rdata_after, obs_to, obs_rv, model_rdata);
      end
    end
  endtask

  task automatic test_reset_mid_wait();
    bit in_wait = 0;
    @(posedge i_clk); #1;
    i_mem_op = 2'b10; i_addr = 32'h0000_5000; i_data_type = 2'b10; i_unsigned = 0;
    for (int c = 0; c < 10 && !in_wait; c++) begin
      i_dmem_gnt = o_dmem_req;
      @(posedge i_clk); #1;
      i_dmem_gnt = 0;
      in_wait = o_stall && !o_dmem_req;
    end
    tests++; if (!in_wait) begin fails++; $display("FAIL rstw_reach_wait: got stall=%0b req=%0b required 1/0", o_stall, o_dmem_req); end
    i_mem_op = 2'b00;
    i_rst_n = 0;
    #2;
    tests++; if (o_stall !== 1'b0 || o_dmem_req !== 1'b0 || o_rdata !== 32'h0) begin fails++; $display("FAIL rstw_cleared: got stall=%0b req=%0b rdata=%h required 0/0/0", o_stall, o_dmem_req, o_rdata); end
    @(posedge i_clk); #1;
    i_rst_n = 1;
    @(posedge i_clk); #1;
    i_dmem_rvalid = 1; i_dmem_rdata = 32'hCAFE_F00D;
    @(negedge i_clk);
    @(posedge i_clk); #1;
    i_dmem_rvalid = 0;
    @(negedge i_clk);
    tests++; if (o_rdata_valid !== 1'b0 || o_rdata !== 32'h0 || o_stall !== 1'b0 || o_dmem_req !== 1'b0) begin
      fails++; $display("FAIL rstw_stray_rvalid: got rv=%0b rdata=%h stall=%0b req=%0b required 0/0/0/0", o_rdata_valid, o_rdata, o_stall, o_dmem_req);
    end
  endtask

  initial begin
    test_reset();
    test_word_store();
    test_byte_load();
    test_half_load();
    test_misaligned();
    test_timeout();
    test_random(60);
    test_reset_mid_wait();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
